// File: rtl/xadc_seq_pkg.sv
// Shared definitions for the XADC DRP current-sense sequencer:
// FSM state encoding, default channel addresses and ADC code width.
package xadc_seq_pkg;

  // Width of an XADC conversion result
  localparam int CODE_W = 12;

  // Default DRP addresses of the two current-sense auxiliary channels
  localparam logic [6:0] CH0_ADDR_DEF = 7'h16;  // VAUX6
  localparam logic [6:0] CH1_ADDR_DEF = 7'h1E;  // VAUX14

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_RDY = 2'd2,
    ST_ACCUM    = 2'd3
  } seq_state_t;

endpackage

// File: rtl/xadc_ch_avg.sv
// Per-channel accumulator: sums 2**AVG_LOG2 codes, publishes the truncated
// average with a one-cycle valid pulse and refreshes the overcurrent flag.
module xadc_ch_avg
  import xadc_seq_pkg::*;
#(
  parameter int                AVG_LOG2 = 2,
  parameter logic [CODE_W-1:0] THRESH   = 12'hE00
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              add_en,
  input  logic [CODE_W-1:0] code,
  output logic [CODE_W-1:0] data,
  output logic              valid,
  output logic              over
);

  // Accumulator wide enough that 2**AVG_LOG2 full-scale codes cannot overflow;
  // the count keeps at least one bit so AVG_LOG2=0 still elaborates cleanly.
  localparam int               ACC_W = CODE_W + AVG_LOG2;
  localparam int               CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'((1 << AVG_LOG2) - 1);

  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  sum;
  logic [CNT_W-1:0]  cnt;
  logic [CODE_W-1:0] avg;

  // Running sum including the incoming sample; the top CODE_W bits are sum >> AVG_LOG2
  assign sum = acc + ACC_W'(code);
  assign avg = sum[ACC_W-1 -: CODE_W];

  // Accumulate samples; on the last one of a block publish average and threshold result
  always_ff @(posedge clk) begin
    if (reset) begin
      acc   <= '0;
      cnt   <= '0;
      data  <= '0;
      valid <= 1'b0;
      over  <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (add_en) begin
        if (cnt == LAST) begin
          acc   <= '0;
          cnt   <= '0;
          data  <= avg;
          valid <= 1'b1;
          over  <= (avg >= THRESH);
        end else begin
          acc <= sum;
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/xadc_drp_sequencer.sv
// XADC DRP read sequencer: on each end-of-conversion reads the next of two
// current-sense channels over DRP (alternating 0,1,0,1), averages the codes
// per channel and flags overcurrent. A missing drdy is bounded by a timeout.
module xadc_drp_sequencer
  import xadc_seq_pkg::*;
#(
  parameter logic [6:0]        CH0_ADDR = CH0_ADDR_DEF,
  parameter logic [6:0]        CH1_ADDR = CH1_ADDR_DEF,
  parameter int                AVG_LOG2 = 2,
  parameter int                TIMEOUT  = 255,
  parameter logic [CODE_W-1:0] THRESH   = 12'hE00
) (
  input  logic              CLK100MHZ,
  input  logic              reset,
  input  logic              eoc,
  input  logic              drdy,
  input  logic [15:0]       do_in,
  output logic [6:0]        daddr,
  output logic              den,
  output logic              dwe,
  output logic [CODE_W-1:0] ch0_data,
  output logic [CODE_W-1:0] ch1_data,
  output logic              ch0_valid,
  output logic              ch1_valid,
  output logic [1:0]        overcurrent,
  output logic              timeout_err,
  output logic              busy
);

  localparam int WCW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  seq_state_t        state;
  seq_state_t        state_nxt;
  logic              ch_sel;
  logic [WCW-1:0]    wait_cnt;
  logic [CODE_W-1:0] code_q;
  logic              timeout_hit;
  logic              unused_do_lsb;

  // The low nibble of DRP data carries no conversion result
  assign unused_do_lsb = ^do_in[3:0];

  assign dwe = 1'b0;

  // drdy takes priority: a timeout only counts when no data arrived this cycle
  assign timeout_hit = (state == ST_WAIT_RDY) && !drdy && (wait_cnt == WCW'(TIMEOUT));

  // State register
  always_ff @(posedge CLK100MHZ) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode and the DRP strobe / busy outputs
  always_comb begin
    state_nxt = state;
    den       = 1'b0;
    busy      = 1'b1;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (eoc) state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        den       = 1'b1;
        state_nxt = ST_WAIT_RDY;
      end
      ST_WAIT_RDY: begin
        if (drdy)             state_nxt = ST_ACCUM;
        else if (timeout_hit) state_nxt = ST_IDLE;
      end
      ST_ACCUM: begin
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Address latch, wait counter, data capture, channel pointer and sticky error
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      ch_sel      <= 1'b0;
      daddr       <= CH0_ADDR;
      wait_cnt    <= '0;
      code_q      <= '0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (eoc) daddr <= ch_sel ? CH1_ADDR : CH0_ADDR;
        end
        ST_ISSUE: begin
          wait_cnt <= '0;
        end
        ST_WAIT_RDY: begin
          if (drdy) begin
            code_q <= do_in[15:4];
          end else if (timeout_hit) begin
            timeout_err <= 1'b1;
            ch_sel      <= ~ch_sel;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_ACCUM: begin
          ch_sel <= ~ch_sel;
        end
        default: ;
      endcase
    end
  end

  xadc_ch_avg #(
    .AVG_LOG2 (AVG_LOG2),
    .THRESH   (THRESH)
  ) u_ch0 (
    .clk    (CLK100MHZ),
    .reset  (reset),
    .add_en ((state == ST_ACCUM) && !ch_sel),
    .code   (code_q),
    .data   (ch0_data),
    .valid  (ch0_valid),
    .over   (overcurrent[0])
  );

  xadc_ch_avg #(
    .AVG_LOG2 (AVG_LOG2),
    .THRESH   (THRESH)
  ) u_ch1 (
    .clk    (CLK100MHZ),
    .reset  (reset),
    .add_en ((state == ST_ACCUM) && ch_sel),
    .code   (code_q),
    .data   (ch1_data),
    .valid  (ch1_valid),
    .over   (overcurrent[1])
  );

endmodule

// File: doc/xadc_drp_sequencer.md
XADC_DRP_SEQUENCER -- requirements
Module: xadc_drp_sequencer

Interface
REQ-001 Parameter CH0_ADDR, default 7'h16, DRP address of current-sense channel 0 (VAUX6).
REQ-002 Parameter CH1_ADDR, default 7'h1E, DRP address of current-sense channel 1 (VAUX14).
REQ-003 Parameter AVG_LOG2, default 2, log2 of samples averaged per channel result (range 0..4).
REQ-004 Parameter TIMEOUT, default 255, maximum cycles to wait for drdy after den.
REQ-005 Parameter THRESH, default 12'hE00, overcurrent threshold on the averaged 12-bit code.
REQ-006 CLK100MHZ  in  1  sole clock; all logic on its rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 eoc  in  1  XADC end-of-conversion pulse.
REQ-009 drdy  in  1  XADC DRP data-ready pulse.
REQ-010 do_in  in  16  XADC DRP read data; code in bits [15:4].
REQ-011 daddr  out  7  DRP address.
REQ-012 den  out  1  DRP enable, single-cycle pulse.
REQ-013 dwe  out  1  DRP write enable, constant 0.
REQ-014 ch0_data, ch1_data  out  12 each  latest averaged code per channel.
REQ-015 ch0_valid, ch1_valid  out  1 each  one-cycle pulse when the matching chN_data updates.
REQ-016 overcurrent  out  2  bit N = 1 while chN_data >= THRESH.
REQ-017 timeout_err  out  1  sticky; set on any drdy timeout.
REQ-018 busy  out  1  high in every state except IDLE.

Function
REQ-019 The FSM SHALL have states IDLE, ISSUE, WAIT_RDY and ACCUM.
REQ-020 IDLE: eoc=1 -> ISSUE on the next edge; daddr SHALL be loaded from the current channel pointer (0 -> CH0_ADDR, 1 -> CH1_ADDR) on that same edge.
REQ-021 ISSUE: den=1 for exactly this one cycle, with daddr stable -> WAIT_RDY; den SHALL rise 1 cycle after eoc.
REQ-022 WAIT_RDY: drdy=1 -> capture do_in[15:4] and go to ACCUM; otherwise increment the wait counter.
REQ-023 WAIT_RDY: wait counter reaching TIMEOUT without drdy -> set timeout_err, leave the accumulator untouched, toggle the channel pointer, go to IDLE.
REQ-024 ACCUM: add the captured code to the current channel's accumulator (12+AVG_LOG2 bits, cannot overflow) and increment its sample count (AVG_LOG2 bits, wraps).
REQ-025 When the count wraps to 0, chN_data SHALL take accumulator >> AVG_LOG2 (truncation), chN_valid SHALL pulse on that same edge, and the accumulator SHALL clear.
REQ-026 ACCUM SHALL last exactly one cycle, toggle the channel pointer, and return to IDLE; channels strictly alternate 0,1,0,1.
REQ-027 An eoc arriving in any state other than IDLE SHALL be dropped, with no queuing.
REQ-028 A drdy arriving outside WAIT_RDY SHALL be ignored.
REQ-029 If drdy and the timeout occur in the same cycle, drdy SHALL win, with no error.
REQ-030 overcurrent[N] SHALL update only when chN_data updates, on the same edge.
REQ-031 AVG_LOG2=0 SHALL give one result per sample, with chN_data equal to the raw code.

Reset
REQ-032 Reset SHALL force: state IDLE, channel pointer 0, daddr=CH0_ADDR, den=0, accumulators, sample counts and wait counter 0, chN_data=0, chN_valid=0, overcurrent=0, timeout_err=0.
REQ-033 Reset asserted mid-transaction SHALL abort it on that edge; a drdy arriving after reset is released SHALL be ignored (REQ-028).

Structure
REQ-034 Shared package xadc_seq_pkg SHALL hold the FSM state encoding, the default channel address constants and the 12-bit code width.
REQ-035 Per-channel accumulate/average/threshold logic SHALL be one sub-module, xadc_ch_avg, instantiated twice.

Verification
REQ-036 AVG_LOG2=0, eoc, drdy 3 cycles later with do_in=16'h8000 -> den 1 cycle after eoc with daddr=7'h16; ch0_data=12'h800; ch0_valid pulse.
REQ-037 Two eocs, codes 12'h100 then 12'h200 -> daddr 7'h16 then 7'h1E; ch0_data=12'h100, ch1_data=12'h200.
REQ-038 AVG_LOG2=2, ch0 codes 12'h100, 12'h101, 12'h102, 12'h104 -> a single ch0_valid after the 4th sample; ch0_data=12'h101.
REQ-039 drdy withheld for 256 cycles -> timeout_err=1, busy=0, ch0_data unchanged; the next eoc targets 7'h1E.
REQ-040 AVG_LOG2=0, ch1 code 12'hE00 then 12'hDFF -> overcurrent[1] goes 1 then 0; eoc during WAIT_RDY -> no second den.
REQ-041 Reset pulsed in WAIT_RDY, then a stray drdy -> all outputs at reset values, no valid pulse.
